// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Purpose  : Shared definitions for the pipelined adder/subtractor: operation
//            encodings, the result-flag bundle and the operand-split check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Status flags that travel with every result.
  typedef struct packed {
    logic cout;  // unsigned carry (add) or unsigned borrow (sub)
    logic ovf;   // signed overflow
    logic zero;  // result is all zeros
    logic neg;   // result MSB
  } addsub_flags_t;

  // The operand must break into a whole number of equal slices.
  function automatic bit split_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_if
// Purpose  : Valid/ready bundle for the pipelined adder/subtractor.
// Ports    : in_valid/in_ready/a/b/sub  - operand side (master drives)
//            out_valid/out_ready/s/cout/ovf/zero/neg - result side
//            master modport = requester, slave modport = arithmetic unit
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero, neg
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_addsub_slice.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice
// Purpose  : Combinational CHUNK-bit full-adder slice used by each pipeline
//            stage of pipelined_addsub.
// Ports    : a     - operand A slice
//            b_eff - operand B slice, already inverted for subtraction
//            cin   - carry into the slice LSB
//            s     - sum slice
//            cout  - carry out of the slice MSB
//            cmsb  - carry into the slice MSB
// Revision : 1.0 - initial release
// ============================================================================
module addsub_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b_eff,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
  assign s       = w_total[CHUNK-1:0];
  assign cout    = w_total[CHUNK];

  // Each sum bit is a ^ b ^ carry-in, so the carry into the MSB is recovered
  // from the MSB sum bit without a second adder.
  assign cmsb    = s[CHUNK-1] ^ a[CHUNK-1] ^ b_eff[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : WIDTH-bit two's-complement adder/subtractor split into
//            STAGES = WIDTH/CHUNK pipeline stages. The carry ripples one
//            slice per cycle. A single global stall freezes every stage.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - pipelined_addsub_if.slave (operands in, result + flags out)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (!split_ok(WIDTH, CHUNK)) begin : g_bad_split
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  logic          w_advance;
  logic          w_out_valid;
  logic          r_cmsb;       // carry into the result MSB, held by the last stage
  addsub_flags_t w_flags;

  // --------------------------------------------------------------------------
  // Stage k adds bits [k*CHUNK +: CHUNK]. It keeps the lower result bits
  // finished so far and the operand bits not yet consumed, so each stage's
  // registers shrink/grow to exactly what later stages still need.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;       // first bit handled here
    localparam int HI = LO + CHUNK;      // first bit handled by later stages

    logic [WIDTH-1:LO] w_a_cur;
    logic [WIDTH-1:LO] w_b_cur;
    logic              w_sub_cur;
    logic              w_cin;
    logic              w_v_cur;
    logic [HI-1:0]     w_s_nxt;
    logic [CHUNK-1:0]  w_b_eff;
    logic [CHUNK-1:0]  w_sum;
    logic              w_cout;
    logic              w_cmsb;

    logic              r_v;
    logic              r_c;
    logic              r_sub;
    logic [HI-1:0]     r_s;

    if (k == 0) begin : g_src_in
      assign w_a_cur   = bus.a;
      assign w_b_cur   = bus.b;
      assign w_sub_cur = bus.sub;
      assign w_cin     = bus.sub;       // +1 completes the two's complement of B
      assign w_v_cur   = bus.in_valid;
      assign w_s_nxt   = w_sum;
    end else begin : g_src_prev
      assign w_a_cur   = g_stage[k-1].g_fwd.r_a;
      assign w_b_cur   = g_stage[k-1].g_fwd.r_b;
      assign w_sub_cur = g_stage[k-1].r_sub;
      assign w_cin     = g_stage[k-1].r_c;
      assign w_v_cur   = g_stage[k-1].r_v;
      assign w_s_nxt   = {w_sum, g_stage[k-1].r_s};
    end

    assign w_b_eff = w_b_cur[LO +: CHUNK] ^ {CHUNK{w_sub_cur}};

    addsub_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a     (w_a_cur[LO +: CHUNK]),
      .b_eff (w_b_eff),
      .cin   (w_cin),
      .s     (w_sum),
      .cout  (w_cout),
      .cmsb  (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_sub <= 1'b0;
        r_s   <= '0;
      end else if (w_advance) begin
        r_v   <= w_v_cur;
        r_c   <= w_cout;
        r_sub <= w_sub_cur;
        r_s   <= w_s_nxt;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;
      logic              w_unused_cmsb;

      // Only the top slice's MSB carry feeds the overflow flag.
      assign w_unused_cmsb = w_cmsb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_advance) begin
          r_a <= w_a_cur[WIDTH-1:HI];
          r_b <= w_b_cur[WIDTH-1:HI];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cmsb <= 1'b0;
        end else if (w_advance) begin
          r_cmsb <= w_cmsb;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake: the whole pipe moves together unless a valid result is blocked.
  // --------------------------------------------------------------------------
  assign w_out_valid  = g_stage[LAST].r_v;
  assign w_advance    = ~w_out_valid | bus.out_ready;
  assign bus.in_ready = w_advance;

  // Flags come only from output registers, so they hold while stalled.
  // zero is qualified by valid so the reset/empty state reads all-zero.
  always_comb begin
    w_flags      = '0;
    w_flags.cout = g_stage[LAST].r_sub ^ g_stage[LAST].r_c;
    w_flags.ovf  = r_cmsb ^ g_stage[LAST].r_c;
    w_flags.zero = w_out_valid & (g_stage[LAST].r_s == '0);
    w_flags.neg  = g_stage[LAST].r_s[WIDTH-1];
  end

  assign bus.out_valid = w_out_valid;
  assign bus.s         = g_stage[LAST].r_s;
  assign bus.cout      = w_flags.cout;
  assign bus.ovf       = w_flags.ovf;
  assign bus.zero      = w_flags.zero;
  assign bus.neg       = w_flags.neg;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Purpose  : Self-checking bench for pipelined_addsub (WIDTH=32, CHUNK=8).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int W      = 32;
  localparam int C      = 8;
  localparam int STAGES = W / C;
  localparam int N_RAND = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(W)) bus();

  pipelined_addsub #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_in     = 0;
  logic [35:0] exp_q[$];
  logic        stall_pend = 1'b0;
  logic [35:0] held = '0;
  logic [35:0] w_obs;

  // Observed result packed as {cout, ovf, zero, neg, s}.
  assign w_obs = {bus.cout, bus.ovf, bus.zero, bus.neg, bus.s};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    longint      ua, ub, sa, sb, ures, sres;
    logic [31:0] r;
    logic        c, o;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub == OP_SUB) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (a < b);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures > 64'sd4294967295);
    end
    o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    r = ures[31:0];
    return {c, o, (r == 32'h0), r[31], r};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: handshake rule, stall stability and in-order scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_pend <= 1'b0;
    end else begin
      check("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid | bus.out_ready));
      if (stall_pend) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1));
        check("stall_hold", 64'(w_obs), 64'(held));
      end
      if (exp_q.size() == 0) begin
        check("no_spurious_out", 64'(bus.out_valid), 64'(0));
      end else if (bus.out_valid && bus.out_ready) begin
        check("result", 64'(w_obs), 64'(exp_q.pop_front()));
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.sub));
        n_in <= n_in + 1;
      end
      stall_pend <= bus.out_valid & !bus.out_ready;
      held       <= w_obs;
    end
  end

  // Hold one transaction until accepted; returns at posedge+1.
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int waited = 0;
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("push_timeout", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  // One transaction into an empty pipe; checks latency and literal result.
  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [35:0] lit);
    int cyc;
    check({name, "_model"}, 64'(model(a, b, sub)), 64'(lit));
    bus.out_ready = 1'b1;
    bus.a = a; bus.b = b; bus.sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(STAGES));
    check({name, "_value"}, 64'(w_obs), 64'(lit));
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;

    // Reset state.
    #2;
    check("reset_outputs", 64'(w_obs), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: {cout, ovf, zero, neg, s}.
    single("add_ff_1",    32'h0000_00FF, 32'h0000_0001, OP_ADD, 36'h0_0000_0100);
    single("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 36'hA_0000_0000);
    single("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 36'h5_8000_0000);
    single("sub_borrow",  32'h0000_0005, 32'h0000_0007, OP_SUB, 36'h9_FFFF_FFFE);
    single("sub_plain",   32'h0000_0007, 32'h0000_0005, OP_SUB, 36'h0_0000_0002);
    single("sub_ovf",     32'h8000_0000, 32'h0000_0001, OP_SUB, 36'h4_7FFF_FFFF);
    single("sub_zero",    32'h0000_0000, 32'h0000_0000, OP_SUB, 36'h2_0000_0000);

    // Back-to-back stream with a 3-cycle output stall.
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push(32'h1111_1111 * i + 32'hF0, 32'h0101_0101 * (7 - i), i[0]);
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    repeat (STAGES + 2) @(posedge clk);
    #1;

    // Reset in the middle of traffic.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(32'hA5A5_0000 + i, 32'h1234_5678, 1'b0);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_outputs", 64'(w_obs), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (10) @(posedge clk);
    #1 check("midrst_no_stale", 64'(bus.out_valid), 64'(0));

    // Random regression with random backpressure.
    cyc = 0;
    while (n_in < N_RAND + 10 && cyc < 60000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = rand_op();
      bus.b         = rand_op();
      bus.sub       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
      cyc++;
    end
    if (n_in < N_RAND + 10) check("rand_timeout", 64'(n_in), 64'(N_RAND + 10));

    // Drain.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_out_valid", 64'(bus.out_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
